// File: rtl/mul_issue_if.sv
// Request/response bundle between the issue stage, mul_issue_unit and writeback.
// master drives requests and consumes results; slave is the issue unit.
interface mul_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_data;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
      input  in_ready, out_valid, out_rd, out_data
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
      output in_ready, out_valid, out_rd, out_data
   );
endinterface

// File: rtl/mul_issue_unit.sv
// Issue/retire controller for a fixed-latency, non-stallable 32x32 signed multiplier.
// Ops are tracked by a tag pipe; results land in a FIFO protected by a credit counter.
module mul_issue_unit #(
   parameter int unsigned MUL_LAT    = 9,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   mul_issue_if.slave  bus,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic        v;
      logic [4:0]  rd;
      logic [1:0]  op;
      logic [31:0] corr;
   } tag_t;

   tag_t          tag_q [MUL_LAT];
   tag_t          tag_d [MUL_LAT];
   logic [4:0]    rd_mem_q   [FIFO_DEPTH];
   logic [31:0]   data_mem_q [FIFO_DEPTH];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        credit_ok;
   logic        accept;
   logic [31:0] corr;
   tag_t        last;
   logic        push;
   logic        pop;
   logic        empty;
   logic        full;
   logic [31:0] push_data;

   always_comb begin
      credit_ok = (cnt_q < CW'(FIFO_DEPTH));
      accept    = bus.in_valid & credit_ok & ~flush;

      // Signed product high word, fixed up for unsigned interpretation of operands.
      case (bus.in_op)
         2'b10:   corr = bus.in_rs2[31] ? bus.in_rs1 : 32'h0;
         2'b11:   corr = (bus.in_rs1[31] ? bus.in_rs2 : 32'h0) +
                         (bus.in_rs2[31] ? bus.in_rs1 : 32'h0);
         default: corr = 32'h0;
      endcase

      tag_d[0] = '{v: accept, rd: bus.in_rd, op: bus.in_op, corr: corr};
      for (int i = 1; i < MUL_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      if (flush) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_d[i].v = 1'b0;
         end
      end

      last      = tag_q[MUL_LAT-1];
      push      = last.v & ~flush;
      push_data = (last.op == 2'b00) ? mul_p[31:0] : (mul_p[63:32] + last.corr);

      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      pop   = ~empty & bus.out_ready & ~flush;

      wptr_d = flush ? '0 : wptr_q + (AW+1)'(push);
      rptr_d = flush ? '0 : rptr_q + (AW+1)'(pop);
      cnt_d  = flush ? '0 : cnt_q + CW'(accept) - CW'(pop);

      mul_a = accept ? bus.in_rs1 : 32'h0;
      mul_b = accept ? bus.in_rs2 : 32'h0;

      bus.in_ready  = credit_ok & ~flush;
      bus.out_valid = ~empty;
      bus.out_rd    = empty ? 5'h0  : rd_mem_q[rptr_q[AW-1:0]];
      bus.out_data  = empty ? 32'h0 : data_mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            tag_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         tag_q  <= tag_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wptr_q[AW-1:0]]   <= last.rd;
         data_mem_q[wptr_q[AW-1:0]] <= push_data;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: tb/tb_mul_issue_unit.sv
// Randomized bench for mul_issue_unit with a queue-based result/timing model
// and an emulated fixed-latency multiplier.
module tb_mul_issue_unit;
   localparam int unsigned MUL_LAT    = 9;
   localparam int unsigned FIFO_DEPTH = 16;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_p;

   mul_issue_if bus ();

   mul_issue_unit #(
      .MUL_LAT    (MUL_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .mul_p (mul_p)
   );

   always #5 clk = ~clk;

   // Multiplier: samples at edge N, product visible after edge N+MUL_LAT-1.
   logic [63:0] prod_q [MUL_LAT];
   always @(posedge clk) begin
      prod_q[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
   end
   assign mul_p = prod_q[MUL_LAT-1];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
      eb = op[1] ? {32'h0, b} : {{32{b[31]}}, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Reference: every accepted op occupies one credit until popped; it becomes
   // visible MUL_LAT edges after acceptance and results leave in order.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int unsigned rdy;
   } ent_t;

   ent_t        mq[$];
   int unsigned edge_n = 0;

   function automatic bit m_out_valid();
      return (mq.size() > 0) && (mq[0].rdy <= edge_n);
   endfunction

   function automatic bit m_in_ready();
      return (mq.size() < FIFO_DEPTH) && !flush;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else begin
         bit pop, acc;
         pop = m_out_valid() && bus.out_ready && !flush;
         acc = bus.in_valid && m_in_ready();
         edge_n++;
         if (flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{bus.in_rd, ref_result(bus.in_op, bus.in_rs1, bus.in_rs2),
                                    edge_n + MUL_LAT});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         bit acc;
         acc = bus.in_valid && m_in_ready();
         chk("in_ready", bus.in_ready, m_in_ready());
         chk("out_valid", bus.out_valid, m_out_valid());
         if (m_out_valid()) begin
            chk("out_rd", bus.out_rd, mq[0].rd);
            chk("out_data", bus.out_data, mq[0].data);
         end
         chk("mul_a", mul_a, acc ? bus.in_rs1 : 32'h0);
         chk("mul_b", mul_b, acc ? bus.in_rs2 : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_random();
      bus.in_op  = 2'($urandom_range(0, 3));
      bus.in_rs1 = rand_opnd();
      bus.in_rs2 = rand_opnd();
      bus.in_rd  = 5'($urandom_range(0, 31));
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rs1   = a;
      bus.in_rs2   = b;
      bus.in_rd    = rd;
      step();
      bus.in_valid = 1'b0;
   endtask

   // Latency counts the accept edge as 1; a result seen right after edge N+9 gives 10.
   task automatic wait_result(input string name, output logic [4:0] rd, output logic [31:0] data,
                              output int lat);
      bit ok;
      ok   = 1'b0;
      lat  = 1;
      rd   = '0;
      data = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) begin
            rd   = bus.out_rd;
            data = bus.out_data;
            ok   = 1'b1;
            break;
         end
         step();
         lat++;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s: no result within 40 cycles (got none, required one)", name);
      end
   endtask

   task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      logic [4:0]  grd;
      logic [31:0] gdata;
      int          lat;
      issue(op, a, b, rd);
      wait_result(name, grd, gdata, lat);
      chk({name, "_lat"}, lat, 10);
      chk({name, "_rd"}, grd, rd);
      chk({name, "_data"}, gdata, exp);
      step();
   endtask

   initial begin
      int nv, first, last, low, accepts, nres;
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'b00;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.in_rd     = '0;
      bus.out_ready = 1'b1;

      // Model pins against hand-computed products.
      chk("ref_mul", ref_result(2'b00, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      chk("ref_mulh", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
      chk("ref_mulhsu", ref_result(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      chk("ref_mulhu", ref_result(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      chk("ref_mulhsu2", ref_result(2'b10, 32'h8000_0000, 32'd2), 32'hFFFF_FFFF);

      step();
      step();
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_rd", bus.out_rd, 5'h0);
      chk("rst_out_data", bus.out_data, 32'h0);
      chk("rst_mul_a", mul_a, 32'h0);
      chk("rst_mul_b", mul_b, 32'h0);
      rst    = 1'b0;
      chk_en = 1'b1;
      step();

      directed("mul", 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
      directed("mulh", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0);
      directed("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
      directed("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
      directed("mulhsu2", 2'b10, 32'h8000_0000, 32'd2, 5'd4, 32'hFFFF_FFFF);

      // Back-to-back stream at full throughput.
      nv = 0; first = -1; last = -1; low = 0;
      for (int i = 0; i < 62; i++) begin
         if (i < 32) begin
            bus.in_valid = 1'b1;
            drive_random();
            if (!bus.in_ready) low++;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.out_valid) begin
            nv++;
            if (first < 0) first = i;
            last = i;
         end
         step();
      end
      chk("b2b_count", nv, 32);
      chk("b2b_span", last - first + 1, 32);
      chk("b2b_in_ready_low", low, 0);

      // Backpressure: credits must cap acceptance at the FIFO depth.
      bus.out_ready = 1'b0;
      accepts = 0;
      for (int i = 0; i < 24; i++) begin
         bus.in_valid = 1'b1;
         drive_random();
         if (bus.in_ready) accepts++;
         step();
      end
      bus.in_valid = 1'b0;
      chk("bp_accepts", accepts, FIFO_DEPTH);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      nres = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) nres++;
         step();
      end
      chk("bp_results", nres, FIFO_DEPTH);

      // Flush with four ops in flight.
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         drive_random();
         flush = (i == 4);
         step();
      end
      bus.in_valid = 1'b0;
      flush = 1'b0;
      nres = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.out_valid) nres++;
         step();
      end
      chk("flush_no_output", nres, 0);
      chk("flush_in_ready", bus.in_ready, 1'b1);
      directed("post_flush", 2'b11, 32'h8000_0001, 32'hC000_0000, 5'd9,
               ref_result(2'b11, 32'h8000_0001, 32'hC000_0000));

      // Asynchronous reset with three results buffered.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         drive_random();
         step();
      end
      bus.in_valid = 1'b0;
      repeat (12) step();
      chk("prerst_out_valid", bus.out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 1'b0);
      chk("arst_in_ready", bus.in_ready, 1'b1);
      chk("arst_out_rd", bus.out_rd, 5'h0);
      chk("arst_out_data", bus.out_data, 32'h0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      directed("post_rst", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17,
               ref_result(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));

      // Random traffic with backpressure and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         flush         = ($urandom_range(0, 59) == 0);
         drive_random();
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      repeat (40) step();
      chk("drain_empty", bus.out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
